trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 30 +++
 rtl/trap_ctrl.sv | 131 +++++++++++++
 tb/tb_trap_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Write-back retirement and fetch-redirect signals shared between the pipeline and trap_ctrl.
// The master side is the pipeline/fetch; the slave side is the trap controller.
interface trap_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            wb_valid_i;
    logic [XLEN-1:0] wb_pc_i;
    logic [31:0]     wb_instr_i;
    logic            fetch_ready_i;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output wb_valid_i,
        output wb_pc_i,
        output wb_instr_i,
        output fetch_ready_i,
        input  redirect_valid_o,
        input  redirect_pc_o
    );

    modport slave (
        input  wb_valid_i,
        input  wb_pc_i,
        input  wb_instr_i,
        input  fetch_ready_i,
        output redirect_valid_o,
        output redirect_pc_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: latches ecall/ebreak/mret at write-back, pulses the CSR update,
// redirects fetch and drains the pipeline for FLUSH_CYCLES before resuming retirement.
module trap_ctrl #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    trap_ctrl_if.slave      bus,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            trap_o,
    output logic [XLEN-1:0] epc_o,
    output logic [XLEN-1:0] cause_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic [31:0]     trap_cnt_o
);

    typedef enum logic [1:0] {StIdle, StTrap, StRedirect, StDrain} state_e;
    typedef enum logic [1:0] {EvNone, EvEcall, EvEbreak, EvMret} event_e;

    localparam logic [31:0] InstrEcall  = 32'h0000_0073;
    localparam logic [31:0] InstrEbreak = 32'h0010_0073;
    localparam logic [31:0] InstrMret   = 32'h3020_0073;
    localparam logic [3:0]  DrainInit   = 4'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    event_e          kind_q, kind_d;
    event_e          ev;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     trap_cnt_q, trap_cnt_d;
    logic            trap, flush, redirect_valid;

    always_comb begin
        ev = EvNone;
        if (bus.wb_instr_i == InstrEcall) begin
            ev = EvEcall;
        end else if (bus.wb_instr_i == InstrEbreak) begin
            ev = EvEbreak;
        end else if (bus.wb_instr_i == InstrMret) begin
            ev = EvMret;
        end
    end

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        target_d       = target_q;
        cnt_d          = cnt_q;
        trap_cnt_d     = trap_cnt_q;
        trap           = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.wb_valid_i && (ev != EvNone)) begin
                    kind_d  = ev;
                    state_d = StTrap;
                    // mret returns through mepc; the trap record stays untouched
                    if (ev != EvMret) begin
                        epc_d   = bus.wb_pc_i;
                        cause_d = (ev == EvEcall) ? XLEN'(11) : XLEN'(3);
                    end
                end
            end
            StTrap: begin
                flush    = 1'b1;
                trap     = (kind_q != EvMret);
                target_d = (kind_q == EvMret) ? mepc_i : (mtvec_i & ~XLEN'(3));
                state_d  = StRedirect;
                if (trap && (trap_cnt_q != '1)) begin
                    trap_cnt_d = trap_cnt_q + 32'd1;
                end
            end
            StRedirect: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                if (bus.fetch_ready_i) begin
                    state_d = StDrain;
                    cnt_d   = DrainInit;
                end
            end
            StDrain: begin
                flush = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            kind_q     <= EvNone;
            epc_q      <= '0;
            cause_q    <= '0;
            target_q   <= '0;
            cnt_q      <= '0;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign trap_o               = trap;
    assign flush_o              = flush;
    assign stall_o              = (state_q != StIdle);
    assign epc_o                = epc_q;
    assign cause_o              = cause_q;
    assign trap_cnt_o           = trap_cnt_q;
    assign bus.redirect_valid_o = redirect_valid;
    assign bus.redirect_pc_o    = target_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected redirect handshakes are queued at stimulus time and
// checked by a negedge monitor; sequence-level properties are checked inline.
module tb_trap_ctrl;

    localparam int unsigned XLEN = 64;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] epc;
        logic [63:0] cause;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mtvec = '0;
    logic [63:0] mepc = '0;
    logic        trap_o, flush_o, stall_o;
    logic [63:0] epc_o, cause_o;
    logic [31:0] trap_cnt_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   trap_pulses = 0;
    int   rv_cycles = 0;
    int   pc_changes = 0;
    int   flush_miss = 0;
    logic prev_trap = 1'b0;
    logic prev_rv = 1'b0;
    logic [63:0] prev_rpc = '0;

    trap_ctrl_if #(.XLEN(XLEN)) bus ();

    trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mtvec_i    (mtvec),
        .mepc_i     (mepc),
        .trap_o     (trap_o),
        .epc_o      (epc_o),
        .cause_o    (cause_o),
        .flush_o    (flush_o),
        .stall_o    (stall_o),
        .trap_cnt_o (trap_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on each redirect handshake, plus sequence bookkeeping.
    always @(negedge clk) begin
        if (!rst) begin
            if (trap_o) begin
                trap_pulses++;
                check("trap_o_single_cycle", {63'd0, prev_trap}, 64'd0);
            end
            if (stall_o && !flush_o) flush_miss++;
            if (bus.redirect_valid_o) begin
                rv_cycles++;
                if (prev_rv && (bus.redirect_pc_o != prev_rpc)) pc_changes++;
            end
            if (bus.redirect_valid_o && bus.fetch_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_handshake: got pc 0x%0h, expected none",
                             bus.redirect_pc_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("redirect_pc", bus.redirect_pc_o, e.pc);
                    check("epc", epc_o, e.epc);
                    check("cause", cause_o, e.cause);
                    check("trap_cnt", {32'd0, trap_cnt_o}, {32'd0, e.cnt});
                end
            end
            prev_trap = trap_o;
            prev_rv   = bus.redirect_valid_o;
            prev_rpc  = bus.redirect_pc_o;
        end else begin
            prev_trap = 1'b0;
            prev_rv   = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
        bus.wb_instr_i = instr;
        bus.wb_pc_i    = pc;
        bus.wb_valid_i = 1'b1;
        tick();
        bus.wb_valid_i = 1'b0;
    endtask

    // Counts negedges with stall_o high until it drops; bounded.
    task automatic wait_idle(input string name, output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stall_o) return;
            n++;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got stall after %0d cycles, expected idle", name, n);
    endtask

    function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] epc,
                                input logic [63:0] cause, input logic [31:0] cnt);
        exp_t e;
        e.pc = pc; e.epc = epc; e.cause = cause; e.cnt = cnt;
        return e;
    endfunction

    initial begin
        int n, p0, rv0, pcc0, fm0;
        logic [31:0] junk [3];
        junk[0] = 32'h0000_0013;
        junk[1] = 32'h0020_0073;
        junk[2] = 32'h3020_0072;

        bus.wb_valid_i    = 1'b0;
        bus.wb_pc_i       = '0;
        bus.wb_instr_i    = '0;
        bus.fetch_ready_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_trap_o", {63'd0, trap_o}, 64'd0);
        check("rst_stall_o", {63'd0, stall_o}, 64'd0);
        check("rst_flush_o", {63'd0, flush_o}, 64'd0);
        check("rst_redirect_valid", {63'd0, bus.redirect_valid_o}, 64'd0);
        check("rst_trap_cnt", {32'd0, trap_cnt_o}, 64'd0);
        rst = 1'b0;

        // ecall, fetch always ready
        mtvec = 64'h8000_0101;
        bus.fetch_ready_i = 1'b1;
        p0 = trap_pulses;
        exp_q.push_back(mk(64'h8000_0100, 64'h8000_0010, 64'd11, 32'd1));
        issue(32'h0000_0073, 64'h8000_0010);
        wait_idle("ecall", n);
        check("ecall_latency", n, 5);
        check("ecall_pulses", trap_pulses - p0, 1);

        // mret: no pulse, epc/cause untouched
        mepc = 64'h8000_0014;
        p0 = trap_pulses;
        exp_q.push_back(mk(64'h8000_0014, 64'h8000_0010, 64'd11, 32'd1));
        issue(32'h3020_0073, 64'h8000_0090);
        wait_idle("mret", n);
        check("mret_latency", n, 5);
        check("mret_pulses", trap_pulses - p0, 0);

        // ebreak with fetch stalled for 4 redirect cycles
        mtvec = 64'h8000_0203;
        bus.fetch_ready_i = 1'b0;
        rv0 = rv_cycles; pcc0 = pc_changes; fm0 = flush_miss;
        exp_q.push_back(mk(64'h8000_0200, 64'h8000_0020, 64'd3, 32'd2));
        issue(32'h0010_0073, 64'h8000_0020);
        repeat (5) tick();
        bus.fetch_ready_i = 1'b1;
        wait_idle("ebreak", n);
        check("ebreak_tail_latency", n, 4);
        check("ebreak_redirect_cycles", rv_cycles - rv0, 5);
        check("ebreak_pc_stable", pc_changes - pcc0, 0);
        check("ebreak_flush_held", flush_miss - fm0, 0);

        // second ecall during drain is ignored
        mtvec = 64'h8000_0101;
        p0 = trap_pulses;
        exp_q.push_back(mk(64'h8000_0100, 64'h8000_0030, 64'd11, 32'd3));
        issue(32'h0000_0073, 64'h8000_0030);
        repeat (2) tick();
        bus.wb_pc_i    = 64'h8000_0040;
        bus.wb_valid_i = 1'b1;
        repeat (2) tick();
        bus.wb_valid_i = 1'b0;
        wait_idle("drain_ignore", n);
        check("drain_ignore_tail", n, 1);
        check("drain_ignore_pulses", trap_pulses - p0, 1);
        check("drain_ignore_cnt", {32'd0, trap_cnt_o}, 64'd3);
        check("drain_ignore_epc", epc_o, 64'h8000_0030);

        // reset while in REDIRECT aborts the sequence
        bus.fetch_ready_i = 1'b0;
        issue(32'h0000_0073, 64'h8000_0050);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_trap_o", {63'd0, trap_o}, 64'd0);
        check("abort_stall_o", {63'd0, stall_o}, 64'd0);
        check("abort_flush_o", {63'd0, flush_o}, 64'd0);
        check("abort_redirect_valid", {63'd0, bus.redirect_valid_o}, 64'd0);
        check("abort_redirect_pc", bus.redirect_pc_o, 64'd0);
        check("abort_epc", epc_o, 64'd0);
        check("abort_cause", cause_o, 64'd0);
        check("abort_trap_cnt", {32'd0, trap_cnt_o}, 64'd0);
        p0 = trap_pulses;
        repeat (3) @(negedge clk);
        check("abort_no_pulse", trap_pulses - p0, 0);
        bus.fetch_ready_i = 1'b1;
        exp_q.push_back(mk(64'h8000_0100, 64'h8000_0060, 64'd11, 32'd1));
        issue(32'h0000_0073, 64'h8000_0060);
        wait_idle("post_abort", n);
        check("post_abort_latency", n, 5);
        check("post_abort_pulses", trap_pulses - p0, 1);

        // non-event words never start a sequence
        p0 = trap_pulses;
        foreach (junk[i]) begin
            bus.wb_instr_i = junk[i];
            bus.wb_pc_i    = 64'h8000_0070;
            bus.wb_valid_i = 1'b1;
            @(negedge clk);
            check("nonevent_stall", {63'd0, stall_o}, 64'd0);
        end
        bus.wb_valid_i = 1'b0;
        check("nonevent_pulses", trap_pulses - p0, 0);
        check("nonevent_cnt", {32'd0, trap_cnt_o}, 64'd1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
